// File: rtl/filter_seq_pkg.sv
// Shared types and field positions for the filter command sequencer.
package filter_seq_pkg;

  typedef enum logic [1:0] {
    OP_NOP         = 2'b00,
    OP_LOAD_COEF   = 2'b01,
    OP_PUSH_SAMPLE = 2'b10,
    OP_CLEAR       = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_COEF,
    ST_PUSH,
    ST_WAIT_RES,
    ST_CLR,
    ST_DONE
  } state_e;

  // cmd_word field positions
  localparam int REQ_BIT = 31;
  localparam int OP_HI   = 30;
  localparam int OP_LO   = 29;
  localparam int ADDR_HI = 27;
  localparam int ADDR_LO = 24;

  // status_word field positions
  localparam int ACK_BIT = 15;
  localparam int ERR_BIT = 14;

endpackage

// File: rtl/toggle_sync.sv
// Two-flop synchronizer for the software request toggle.
module toggle_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; the first may go metastable, the second is clean.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/filter_sequencer.sv
// Turns toggle-handshaked PIO commands into single-cycle filter strobes,
// waits for filter results under a watchdog and reports status back.
module filter_sequencer
  import filter_seq_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int RES_W   = 14,
  parameter int COEF_AW = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [31:0]        cmd_word,
  output logic [15:0]        status_word,
  output logic               coef_wr,
  output logic [COEF_AW-1:0] coef_addr,
  output logic [DATA_W-1:0]  coef_data,
  output logic               filt_clr,
  output logic               smp_valid,
  output logic [DATA_W-1:0]  smp_data,
  input  logic               smp_ready,
  input  logic               res_valid,
  input  logic [RES_W-1:0]   res_data,
  output logic               busy
);

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              req_seen_q, req_seen_d;
  logic [30:0]       cmd_q, cmd_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [RES_W-1:0]  res_q, res_d;

  logic              req_sync;
  logic              pending;
  opcode_e           op;

  toggle_sync u_req_sync (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .d_i    (cmd_word[REQ_BIT]),
    .q_o    (req_sync)
  );

  assign pending = req_sync ^ req_seen_q;
  assign op      = opcode_e'(cmd_q[OP_HI:OP_LO]);

  // Bit 28 and bits [23:16] of the command carry no meaning.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^{cmd_q[28], cmd_q[23:16]};

  // State, command latch, watchdog and status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      req_seen_q <= 1'b0;
      cmd_q      <= '0;
      tmo_q      <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      req_seen_q <= req_seen_d;
      cmd_q      <= cmd_d;
      tmo_q      <= tmo_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      res_q      <= res_d;
    end
  end

  // Next-state logic and the single-cycle strobes decoded from state.
  always_comb begin
    state_d    = state_q;
    req_seen_d = req_seen_q;
    cmd_d      = cmd_q;
    tmo_d      = tmo_q;
    ack_d      = ack_q;
    err_d      = err_q;
    res_d      = res_q;
    coef_wr    = 1'b0;
    filt_clr   = 1'b0;
    smp_valid  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pending) begin
          cmd_d      = cmd_word[30:0];
          req_seen_d = req_sync;
          state_d    = ST_DECODE;
        end
      end

      ST_DECODE: begin
        err_d = 1'b0;
        case (op)
          OP_NOP:         state_d = ST_DONE;
          OP_LOAD_COEF:   state_d = ST_COEF;
          OP_PUSH_SAMPLE: begin
            state_d = ST_PUSH;
            tmo_d   = TMO_LOAD;
          end
          OP_CLEAR:       state_d = ST_CLR;
          default:        state_d = ST_DONE;
        endcase
      end

      ST_COEF: begin
        coef_wr = 1'b1;
        state_d = ST_DONE;
      end

      ST_CLR: begin
        filt_clr = 1'b1;
        state_d  = ST_DONE;
      end

      ST_PUSH: begin
        // A handshake on the last watchdog cycle still counts as a transfer.
        smp_valid = 1'b1;
        if (smp_ready) begin
          state_d = ST_WAIT_RES;
          if (tmo_q != '0) tmo_d = tmo_q - TMO_W'(1);
        end else if (tmo_q == '0) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end

      ST_WAIT_RES: begin
        // A result arriving with the watchdog at zero wins over the timeout.
        if (res_valid) begin
          res_d   = res_data;
          state_d = ST_DONE;
        end else if (tmo_q == '0) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end

      ST_DONE: begin
        ack_d   = req_seen_q;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign coef_addr   = COEF_AW'(cmd_q[ADDR_HI:ADDR_LO]);
  assign coef_data   = cmd_q[DATA_W-1:0];
  assign smp_data    = cmd_q[DATA_W-1:0];
  assign busy        = (state_q != ST_IDLE);

  always_comb begin
    status_word          = '0;
    status_word[ACK_BIT] = ack_q;
    status_word[ERR_BIT] = err_q;
    status_word[13:0]    = 14'(res_q);
  end

endmodule
